// File: rtl/hh_tdm_scheduler_if.sv
// Core-side link between the TDM scheduler and the shared HH update core.
// Latency: n/a (wires only); the core answers a core_start with a core_done pulse.
// Backpressure: none; the scheduler issues one request and waits for the done pulse.
//
// Signals:
//   core_start    scheduler -> core : one-cycle request strobe
//   core_state_o  scheduler -> core : packed {V,n,m,h} of the neuron being updated
//   core_cur_o    scheduler -> core : stimulus current for that neuron
//   core_done     core -> scheduler : one-cycle result-valid strobe
//   core_state_i  core -> scheduler : updated packed {V,n,m,h}
interface hh_tdm_scheduler_if #(
    parameter int STATE_W = 14
);
    logic                   core_start;
    logic [4*STATE_W-1:0]   core_state_o;
    logic [STATE_W-1:0]     core_cur_o;
    logic                   core_done;
    logic [4*STATE_W-1:0]   core_state_i;

    modport master (
        output core_start,
        output core_state_o,
        output core_cur_o,
        input  core_done,
        input  core_state_i
    );

    modport slave (
        input  core_start,
        input  core_state_o,
        input  core_cur_o,
        output core_done,
        output core_state_i
    );
endinterface

// File: rtl/hh_tdm_scheduler.sv
// Time-division scheduler sharing one HH update core across NUM_NEURONS virtual neurons.
// Latency: 3 cycles + core latency per neuron; epoch = NUM_NEURONS * (3 + core latency).
// Backpressure: ticks while busy are dropped (sticky overrun); a missing core_done aborts after TIMEOUT.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 low freezes the FSM and wait counter, ticks ignored
//   tick                starts one integration epoch when idle
//   cur_we/addr/data    per-neuron stimulus current write (accepted any time)
//   core                master side of hh_tdm_scheduler_if (start/state/current out, done/state in)
//   rd_addr / rd_v      combinational readback of a neuron's V
//   spike_valid/id      one-cycle spike report during write-back
//   busy, epoch_done    FSM not idle / last neuron written back
//   overrun, timeout_err sticky error flags, cleared only by reset
// Optional build macro HH_SPIKE_COUNT_EN: per-neuron 8-bit saturating spike
// counters with ports cnt_clr (clear all) and rd_cnt (count of neuron rd_addr).
module hh_tdm_scheduler #(
    parameter int                           NUM_NEURONS = 4,
    parameter int                           STATE_W     = 14,
    parameter logic signed [STATE_W-1:0]    SPIKE_TH    = 14'sd1024,
    parameter logic [4*STATE_W-1:0]         INIT_STATE  = '0,
    parameter int                           TIMEOUT     = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ena,
    input  logic                            tick,
    input  logic                            cur_we,
    input  logic [$clog2(NUM_NEURONS)-1:0]  cur_addr,
    input  logic [7:0]                      cur_data,
    hh_tdm_scheduler_if.master              core,
    input  logic [$clog2(NUM_NEURONS)-1:0]  rd_addr,
    output logic [STATE_W-1:0]              rd_v,
    output logic                            spike_valid,
    output logic [$clog2(NUM_NEURONS)-1:0]  spike_id,
    output logic                            busy,
    output logic                            epoch_done,
    output logic                            overrun,
    output logic                            timeout_err
`ifdef HH_SPIKE_COUNT_EN
    ,
    input  logic                            cnt_clr,
    output logic [7:0]                      rd_cnt
`endif
);
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int PW    = 4 * STATE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       wait_cnt_q;
    logic [PW-1:0]          res_q;
    logic [PW-1:0]          nrn_q [NUM_NEURONS];
    logic [7:0]             cur_q [NUM_NEURONS];

    logic                   core_start_q;
    logic [PW-1:0]          core_state_q;
    logic [STATE_W-1:0]     core_cur_q;
    logic                   spike_q;
    logic [IDX_W-1:0]       spike_id_q;
    logic                   epoch_done_q;
    logic                   overrun_q;
    logic                   timeout_q;

    logic signed [STATE_W-1:0] old_v;
    logic signed [STATE_W-1:0] new_v;
    logic                      spike_d;

    // Spike decision is made as the result arrives so that the pulse is
    // registered and lines up with the WRITE cycle. The neuron's stored V is
    // only modified in WRITE, so old_v is still the pre-update value here.
    assign old_v   = nrn_q[idx_q][PW-1 -: STATE_W];
    assign new_v   = core.core_state_i[PW-1 -: STATE_W];
    assign spike_d = (old_v < SPIKE_TH) && (new_v >= SPIKE_TH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wait_cnt_q   <= '0;
            res_q        <= '0;
            core_start_q <= 1'b0;
            core_state_q <= '0;
            core_cur_q   <= '0;
            spike_q      <= 1'b0;
            spike_id_q   <= '0;
            epoch_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            // Pulses last one cycle regardless of ena.
            core_start_q <= 1'b0;
            spike_q      <= 1'b0;
            spike_id_q   <= '0;
            epoch_done_q <= 1'b0;

            if (tick && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            if (ena) begin
                unique case (state_q)
                    IDLE: begin
                        if (tick) begin
                            idx_q   <= '0;
                            state_q <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        // Current is sampled from the register here, so a write
                        // landing in this same cycle only reaches the next epoch.
                        core_start_q <= 1'b1;
                        core_state_q <= nrn_q[idx_q];
                        core_cur_q   <= {cur_q[idx_q], {(STATE_W-8){1'b0}}};
                        wait_cnt_q   <= '0;
                        state_q      <= WAIT;
                    end
                    WAIT: begin
                        if (core.core_done) begin
                            res_q        <= core.core_state_i;
                            spike_q      <= spike_d;
                            spike_id_q   <= spike_d ? idx_q : '0;
                            epoch_done_q <= (idx_q == IDX_W'(NUM_NEURONS - 1));
                            state_q      <= WRITE;
                        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                            // TIMEOUT cycles spent in WAIT: abandon the epoch.
                            timeout_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end
                    WRITE: begin
                        if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Neuron state store: written at the end of WRITE, so a readback of idx
    // during WRITE still shows the old V.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                nrn_q[i] <= INIT_STATE;
            end
        end else if (ena && (state_q == WRITE)) begin
            nrn_q[idx_q] <= res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cur_q[i] <= '0;
            end
        end else if (cur_we) begin
            cur_q[cur_addr] <= cur_data;
        end
    end

`ifdef HH_SPIKE_COUNT_EN
    logic [7:0] cnt_q [NUM_NEURONS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (spike_q && (cnt_q[spike_id_q] != 8'hFF)) begin
            cnt_q[spike_id_q] <= cnt_q[spike_id_q] + 8'd1;
        end
    end

    assign rd_cnt = cnt_q[rd_addr];
`endif

    assign core.core_start   = core_start_q;
    assign core.core_state_o = core_state_q;
    assign core.core_cur_o   = core_cur_q;

    assign rd_v        = nrn_q[rd_addr][PW-1 -: STATE_W];
    assign spike_valid = spike_q;
    assign spike_id    = spike_id_q;
    assign busy        = (state_q != IDLE);
    assign epoch_done  = epoch_done_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
endmodule

// File: tb/tb_hh_tdm_scheduler.sv
// Self-checking bench for hh_tdm_scheduler with a behavioural core model.
// Latency: core model answers each core_start after a per-neuron programmable delay.
// Backpressure: none modelled; a hang mode never answers to exercise the timeout.
module tb_hh_tdm_scheduler;
    localparam int N   = 4;
    localparam int SW  = 14;
    localparam int IW  = 2;
    localparam int TO  = 255;
    localparam logic signed [SW-1:0] TH   = 14'sd1024;
    localparam logic [4*SW-1:0]      INIT = {14'd100, 14'd5, 14'd6, 14'd7};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b0;
    logic           tick = 1'b0;
    logic           cur_we = 1'b0;
    logic [IW-1:0]  cur_addr = '0;
    logic [7:0]     cur_data = '0;
    logic [IW-1:0]  rd_addr = '0;
    logic [SW-1:0]  rd_v;
    logic           spike_valid;
    logic [IW-1:0]  spike_id;
    logic           busy;
    logic           epoch_done;
    logic           overrun;
    logic           timeout_err;
`ifdef HH_SPIKE_COUNT_EN
    logic           cnt_clr = 1'b0;
    logic [7:0]     rd_cnt;
`endif

    hh_tdm_scheduler_if #(.STATE_W(SW)) cif ();

    hh_tdm_scheduler #(
        .NUM_NEURONS (N),
        .STATE_W     (SW),
        .SPIKE_TH    (TH),
        .INIT_STATE  (INIT),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .tick        (tick),
        .cur_we      (cur_we),
        .cur_addr    (cur_addr),
        .cur_data    (cur_data),
        .core        (cif),
        .rd_addr     (rd_addr),
        .rd_v        (rd_v),
        .spike_valid (spike_valid),
        .spike_id    (spike_id),
        .busy        (busy),
        .epoch_done  (epoch_done),
        .overrun     (overrun),
        .timeout_err (timeout_err)
`ifdef HH_SPIKE_COUNT_EN
        ,
        .cnt_clr     (cnt_clr),
        .rd_cnt      (rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ep_cnt = 0;
    int done_cyc = -1;
    int st_cnt = 0;
    int spk_q[$];

    // Reference model: architectural neuron state and currents.
    logic [4*SW-1:0] mdl_st  [N];
    logic [7:0]      mdl_cur [N];
    // Per-epoch plan: what the core returns, its latency, and the current each neuron must see.
    logic [4*SW-1:0] res_tab [N];
    int              lat_tab [N];
    logic [SW-1:0]   exp_cur [N];
    bit              core_hang = 1'b0;
    int              core_idx = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [4*SW-1:0] inc_fields(input logic [4*SW-1:0] s);
        logic [4*SW-1:0] r;
        for (int f = 0; f < 4; f++) begin
            r[f*SW +: SW] = s[f*SW +: SW] + 14'd1;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (epoch_done) begin
            ep_cnt++;
            done_cyc = cyc;
        end
        if (spike_valid) spk_q.push_back(int'(spike_id));
        if (cif.core_start) st_cnt++;
    end

    // Core model: checks what is presented, answers after lat_tab cycles.
    initial begin
        int k;
        cif.core_done    = 1'b0;
        cif.core_state_i = '0;
        forever begin
            @(posedge clk); #1;
            if (cif.core_start && !core_hang) begin
                k = core_idx;
                core_idx++;
                if (k < N) begin
                    check("core_state", cif.core_state_o, mdl_st[k]);
                    check("core_cur", cif.core_cur_o, exp_cur[k]);
                end
                repeat (lat_tab[k % N]) @(posedge clk);
                #1;
                cif.core_done    = 1'b1;
                cif.core_state_i = res_tab[k % N];
                @(posedge clk); #1;
                cif.core_done    = 1'b0;
            end
        end
    end

    task automatic plan_inc(input int lat);
        for (int i = 0; i < N; i++) begin
            res_tab[i] = inc_fields(mdl_st[i]);
            lat_tab[i] = lat;
            exp_cur[i] = {mdl_cur[i], 6'b0};
        end
    endtask

    task automatic plan_hold(input int lat);
        for (int i = 0; i < N; i++) begin
            res_tab[i] = mdl_st[i];
            lat_tab[i] = lat;
            exp_cur[i] = {mdl_cur[i], 6'b0};
        end
    endtask

    task automatic set_v(input int i, input logic [SW-1:0] v);
        res_tab[i][4*SW-1 -: SW] = v;
    endtask

    task automatic wr_cur(input int a, input logic [7:0] d);
        @(posedge clk); #1;
        cur_we = 1'b1; cur_addr = IW'(a); cur_data = d;
        @(posedge clk); #1;
        cur_we = 1'b0;
        mdl_cur[a] = d;
    endtask

    task automatic check_all_v(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_addr = IW'(i);
            #1;
            check(tag, rd_v, mdl_st[i][4*SW-1 -: SW]);
        end
    endtask

    // One epoch. wr_off>0 issues a current write that many cycles after the
    // tick cycle; xtick_off>0 re-asserts tick that many cycles after it.
    task automatic run_epoch(input int wr_off, input int wr_addr, input logic [7:0] wr_data,
                             input int xtick_off);
        int t, len, ep0, s0, o;
        int exp_spk[$];
        logic signed [SW-1:0] ov, nv;
        len = 0;
        for (int i = 0; i < N; i++) begin
            o = 1 + len;  // cycle offset of neuron i's issue relative to the tick cycle
            exp_cur[i] = {((wr_off > 0) && (wr_addr == i) && (wr_off < o)) ? wr_data : mdl_cur[i], 6'b0};
            ov = mdl_st[i][4*SW-1 -: SW];
            nv = res_tab[i][4*SW-1 -: SW];
            if ((ov < TH) && (nv >= TH)) exp_spk.push_back(i);
            len += 3 + lat_tab[i];
        end
        core_idx = 0;
        spk_q.delete();
        ep0 = ep_cnt;
        s0  = st_cnt;
        @(posedge clk); #1;
        tick = 1'b1;
        t = cyc;
        fork
            begin
                @(posedge clk); #1;
                tick = 1'b0;
            end
            if (wr_off > 0) begin
                repeat (wr_off) @(posedge clk);
                #1;
                cur_we = 1'b1; cur_addr = IW'(wr_addr); cur_data = wr_data;
                @(posedge clk); #1;
                cur_we = 1'b0;
            end
            if (xtick_off > 0) begin
                repeat (xtick_off) @(posedge clk);
                #1;
                tick = 1'b1;
                @(posedge clk); #1;
                tick = 1'b0;
            end
        join
        while ((ep_cnt == ep0) && (cyc - t < len + 40)) @(negedge clk);
        check("ep_len", done_cyc - t, len);
        repeat (3) @(negedge clk);
        check("ep_once", ep_cnt - ep0, 1);
        check("idle_after", busy, 1'b0);
        check("starts", st_cnt - s0, N);
        check("spk_n", spk_q.size(), exp_spk.size());
        for (int j = 0; (j < spk_q.size()) && (j < exp_spk.size()); j++) begin
            check("spk_id", spk_q[j], exp_spk[j]);
        end
        for (int i = 0; i < N; i++) mdl_st[i] = res_tab[i];
        if (wr_off > 0) mdl_cur[wr_addr] = wr_data;
        check_all_v("rd_v");
    endtask

    initial begin
        int t, ep0;
        for (int i = 0; i < N; i++) begin
            mdl_st[i]  = INIT;
            mdl_cur[i] = '0;
            lat_tab[i] = 2;
            exp_cur[i] = '0;
            res_tab[i] = INIT;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_start", cif.core_start, 1'b0);
        check("rst_spike", spike_valid, 1'b0);
        check("rst_spike_id", spike_id, '0);
        check("rst_epoch", epoch_done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_core_state", cif.core_state_o, '0);
        check("rst_core_cur", cif.core_cur_o, '0);
        check_all_v("rst_rd_v");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ena   = 1'b1;

        // Basic epoch, state+1 after 2 cycles: 20-cycle epoch
        plan_inc(2);
        run_epoch(0, 0, 8'h00, 0);

        // Current applied only to neuron 2
        wr_cur(2, 8'h40);
        plan_inc(2);
        run_epoch(0, 0, 8'h00, 0);

        // Write in neuron 1's issue cycle (offset 6) is not seen this epoch
        plan_inc(2);
        run_epoch(6, 1, 8'h22, 0);
        // Write well before neuron 3's issue (offset 16) is seen
        plan_inc(2);
        run_epoch(5, 3, 8'h33, 0);

        // Threshold crossing on neuron 1: 1023 -> 1024 spikes, 1024 -> 1100 does not
        plan_inc(2); set_v(1, 14'd1023);
        run_epoch(0, 0, 8'h00, 0);
        plan_inc(2); set_v(1, 14'd1024);
        run_epoch(0, 0, 8'h00, 0);
        plan_inc(2); set_v(1, 14'd1100);
        run_epoch(0, 0, 8'h00, 0);

        // Tick while busy
        check("ovr_before", overrun, 1'b0);
        plan_inc(2);
        run_epoch(0, 0, 8'h00, 5);
        check("ovr_after", overrun, 1'b1);

        // Core never answers
        check("to_before", timeout_err, 1'b0);
        core_hang = 1'b1;
        ep0 = ep_cnt;
        @(posedge clk); #1;
        tick = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        tick = 1'b0;
        while (busy && (cyc - t < 400)) @(negedge clk);
        check("to_idle_cycle", cyc - t, 257);
        check("to_flag", timeout_err, 1'b1);
        check("to_no_epoch", ep_cnt - ep0, 0);
        check_all_v("to_rd_v");
        core_hang = 1'b0;
        plan_inc(2);
        run_epoch(0, 0, 8'h00, 0);

        // ena low: tick ignored
        ena = 1'b0;
        @(posedge clk); #1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (3) @(negedge clk);
        check("ena_busy", busy, 1'b0);
        ena = 1'b1;

        // Asynchronous reset in the middle of WAIT
        plan_inc(2);
        core_idx = 0;
        @(posedge clk); #1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_overrun", overrun, 1'b0);
        check("arst_timeout", timeout_err, 1'b0);
        check("arst_core_state", cif.core_state_o, '0);
        for (int i = 0; i < N; i++) begin
            mdl_st[i]  = INIT;
            mdl_cur[i] = '0;
        end
        check_all_v("arst_rd_v");
        repeat (4) @(posedge clk);
        #1;
        check("arst_epoch", epoch_done, 1'b0);
        rst_n = 1'b1;
        plan_inc(2);
        run_epoch(0, 0, 8'h00, 0);

        // Randomized epochs
        for (int e = 0; e < 10; e++) begin
            int len, wo, nw;
            logic [SW-1:0] v;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) wr_cur($urandom_range(0, N-1), 8'($urandom));
            len = 0;
            for (int i = 0; i < N; i++) begin
                lat_tab[i] = $urandom_range(1, 4);
                len += 3 + lat_tab[i];
                if ($urandom_range(0, 1) == 1) v = 14'(1004 + $urandom_range(0, 40));
                else v = 14'($urandom);
                res_tab[i] = {v, 14'($urandom), 14'($urandom), 14'($urandom)};
            end
            wo = $urandom_range(1, len - 2);
            run_epoch(wo, $urandom_range(0, N-1), 8'($urandom), 0);
        end

`ifdef HH_SPIKE_COUNT_EN
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        rd_addr = '0;
        #1;
        check("cnt_clr_start", rd_cnt, 8'd0);
        for (int k = 1; k <= 300; k++) begin
            plan_hold(1); set_v(0, 14'd0);
            run_epoch(0, 0, 8'h00, 0);
            plan_hold(1); set_v(0, 14'd2000);
            run_epoch(0, 0, 8'h00, 0);
            rd_addr = '0;
            #1;
            check("cnt", rd_cnt, (k > 255) ? 8'd255 : 8'(k));
        end
        rd_addr = IW'(1);
        #1;
        check("cnt_other", rd_cnt, 8'd0);
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        rd_addr = '0;
        #1;
        check("cnt_clr_end", rd_cnt, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/hh_tdm_scheduler.md
Name: hh_tdm_scheduler

Overview:
Time-division scheduler that shares one Hodgkin-Huxley update core across NUM_NEURONS virtual neurons. It holds per-neuron state (V, n, m, h) and a per-neuron stimulus current. On each integration tick it sequences the core once per neuron in round-robin order, writes back the results, and reports threshold-crossing spikes. It sits between the top-level I/O wrapper and the hh datapath core.

Parameters:
NUM_NEURONS, 4, number of virtual neurons; power of two, 2..8
STATE_W, 14, width of each state variable (V, n, m, h), signed fixed-point
SPIKE_TH, 14'sd1024, signed V threshold for spike detection
INIT_STATE, 56'h0, reset value of every neuron's packed state {V,n,m,h}; V in MSBs
TIMEOUT, 255, maximum cycles spent in WAIT before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  enable; low freezes the FSM and ignores ticks
tick  in  1  single-cycle pulse that starts one integration epoch
cur_we  in  1  stimulus current write strobe
cur_addr  in  $clog2(NUM_NEURONS)  neuron index for the current write
cur_data  in  8  stimulus current; applied to the core as {cur_data, 6'b0}
core_start  out  1  one-cycle start pulse to the core
core_state_o  out  4*STATE_W  packed state presented to the core
core_cur_o  out  STATE_W  current presented to the core
core_done  in  1  core result valid, one-cycle pulse
core_state_i  in  4*STATE_W  updated packed state from the core
rd_addr  in  $clog2(NUM_NEURONS)  readback neuron select
rd_v  out  STATE_W  V of neuron rd_addr (combinational read of the state regs)
spike_valid  out  1  one-cycle pulse on a detected spike
spike_id  out  $clog2(NUM_NEURONS)  neuron index for spike_valid
busy  out  1  high whenever the FSM is not in IDLE
epoch_done  out  1  one-cycle pulse after the last neuron is written back
overrun  out  1  sticky: a tick arrived while busy
timeout_err  out  1  sticky: core_done was not seen within TIMEOUT cycles

Behaviour:
- Reset:
  - all state regs = INIT_STATE; all currents = 0; idx = 0; FSM = IDLE.
  - all outputs 0 except rd_v = INIT_STATE V field.
- FSM: IDLE -> ISSUE -> WAIT -> WRITE -> (ISSUE | IDLE).
  - IDLE: if tick and ena, then idx <= 0 and go to ISSUE.
  - ISSUE:
    - core_start = 1 for exactly one cycle.
    - core_state_o and core_cur_o are registered from neuron idx and held stable until the next ISSUE.
    - Next state is WAIT.
  - WAIT:
    - On core_done, capture core_state_i and go to WRITE.
    - The wait counter increments every cycle. When it reaches TIMEOUT: set timeout_err, discard the result, go to IDLE, and do not pulse epoch_done.
  - WRITE:
    - Write the captured state to neuron idx.
    - Spike check: old V < SPIKE_TH and new V >= SPIKE_TH (signed). If true, spike_valid = 1 and spike_id = idx in the same cycle.
    - If idx == NUM_NEURONS-1: pulse epoch_done and go to IDLE. Otherwise idx++ and go to ISSUE.
- Per-neuron latency: 3 cycles + core latency. Epoch length: NUM_NEURONS*(3 + core latency) cycles.
- tick while busy: dropped; overrun <= 1.
- core_done outside WAIT: ignored.
- ena = 0: FSM holds its state and the wait counter holds; tick is ignored; cur_we still accepted.
- Current writes:
  - Accepted in any state and take effect the next cycle.
  - The current used for a neuron is the value sampled at its ISSUE.
  - A write to idx in the ISSUE cycle itself is seen at the next epoch.
- rd_addr reading neuron idx during WRITE returns the old V. The new V is visible the following cycle.
- Sticky flags overrun and timeout_err clear only on reset.
- Reset mid-epoch: immediate return to IDLE. No pending pulses survive. State regs revert to INIT_STATE.

Optional Feature:
HH_SPIKE_COUNT_EN:
- Defined: each neuron has an 8-bit saturating spike counter. It increments on that neuron's spike_valid and holds at 255. Reset value is 0.
- Adds ports cnt_clr (in, 1; clears all counters, priority over increment) and rd_cnt (out, 8; counter of neuron rd_addr).
- Undefined: no counters and neither port exists.

Test Plan:
- Reset then one tick, with the core model returning state+1 after 2 cycles:
  - 4 core_start pulses, for idx 0..3.
  - epoch_done exactly 20 cycles after the tick.
  - rd_v for every neuron = INIT V + 1.
- cur_we addr=2, data=8'h40, then tick: core_cur_o = 14'h1000 while idx=2; all other neurons see 0.
- Core model forces V = 1024 for neuron 1 (old V = 1023): single spike_valid with spike_id=1. A second epoch with V = 1100: no spike.
- Tick asserted again 5 cycles into an epoch: overrun=1, epoch continues normally, exactly one epoch_done.
- Core model never asserts core_done: timeout_err=1 after 255 WAIT cycles, FSM to IDLE, busy=0, no epoch_done. The next tick runs normally.
- Async reset asserted mid-WAIT: busy=0 immediately, state regs = INIT_STATE. With HH_SPIKE_COUNT_EN: 300 spikes on neuron 0 -> rd_cnt = 255; cnt_clr -> 0.
